// File: rtl/hazard_unit_param.sv
// Scoreboard of in-flight register writers over DEPTH stages after issue: forwarding selects,
// load-use stall and flush bubbles. Optional stall/flush counters behind HAZARD_PERF_CNT_EN.
module hazard_unit_param #(
   parameter int DEPTH            = 2,
   parameter int NUM_SRC          = 2,
   parameter int REG_ADDR_W       = 5,
   parameter int LOAD_READY_STAGE = 2,
   parameter int FLUSH_STAGE      = 1,
   localparam int SEL_W           = $clog2(DEPTH + 1)
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          issue_valid,
   input  logic [NUM_SRC*REG_ADDR_W-1:0] issue_rs,
   input  logic [NUM_SRC-1:0]            issue_rs_used,
   input  logic [REG_ADDR_W-1:0]         issue_rd,
   input  logic                          issue_wen,
   input  logic                          issue_load,
   input  logic                          flush,
   output logic                          stall,
   output logic [NUM_SRC*SEL_W-1:0]      fwd_sel,
   output logic [DEPTH-1:0]              stage_valid,
   output logic                          wb_wen,
   output logic [REG_ADDR_W-1:0]         wb_rd
`ifdef HAZARD_PERF_CNT_EN
   ,
   output logic [31:0]                   perf_stall_cnt,
   output logic [31:0]                   perf_flush_cnt
`endif
);

   logic [DEPTH:1]          v_q, wen_q, load_q;
   logic [REG_ADDR_W-1:0]   rd_q [1:DEPTH];

   logic                    raw_stall;
   logic [REG_ADDR_W-1:0]   rs;
   int                      hit_k;
   logic                    hit_load;

   // Scan oldest to youngest so the youngest matching writer overrides.
   always_comb begin
      raw_stall = 1'b0;
      fwd_sel   = '0;
      rs        = '0;
      hit_k     = 0;
      hit_load  = 1'b0;
      for (int s = 0; s < NUM_SRC; s++) begin
         rs       = issue_rs[s*REG_ADDR_W +: REG_ADDR_W];
         hit_k    = 0;
         hit_load = 1'b0;
         for (int k = DEPTH; k >= 1; k--) begin
            if (v_q[k] && wen_q[k] && (rd_q[k] == rs) && (rs != '0) &&
                issue_rs_used[s] && issue_valid) begin
               hit_k    = k;
               hit_load = load_q[k];
            end
         end
         fwd_sel[s*SEL_W +: SEL_W] = SEL_W'(hit_k);
         if ((hit_k != 0) && hit_load && (hit_k < LOAD_READY_STAGE))
            raw_stall = 1'b1;
      end
   end

   assign stall = raw_stall & ~flush;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         v_q    <= '0;
         wen_q  <= '0;
         load_q <= '0;
         for (int k = 1; k <= DEPTH; k++)
            rd_q[k] <= '0;
      end else begin
         // Younger-than-resolver stages are killed on flush; the resolver itself moves on intact.
         for (int k = DEPTH - 1; k >= 1; k--) begin
            v_q[k+1]    <= v_q[k] & ~(flush && ((k + 1) <= FLUSH_STAGE));
            wen_q[k+1]  <= wen_q[k];
            load_q[k+1] <= load_q[k];
            rd_q[k+1]   <= rd_q[k];
         end
         v_q[1]    <= issue_valid & ~stall & ~flush;
         wen_q[1]  <= issue_wen;
         load_q[1] <= issue_load;
         rd_q[1]   <= issue_rd;
      end
   end

   assign stage_valid = v_q;
   assign wb_wen      = v_q[DEPTH] & wen_q[DEPTH] & (rd_q[DEPTH] != '0);
   assign wb_rd       = rd_q[DEPTH];

`ifdef HAZARD_PERF_CNT_EN
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         perf_stall_cnt <= '0;
         perf_flush_cnt <= '0;
      end else begin
         if (stall && (perf_stall_cnt != 32'hFFFF_FFFF))
            perf_stall_cnt <= perf_stall_cnt + 32'd1;
         if (flush && (perf_flush_cnt != 32'hFFFF_FFFF))
            perf_flush_cnt <= perf_flush_cnt + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_hazard_unit_param.sv
// Directed vector bench for hazard_unit_param at default parameters (DEPTH=2, LOAD_READY_STAGE=2, FLUSH_STAGE=1).
module tb_hazard_unit_param;

   localparam int SEL_W = 2;

   logic        clk = 1'b0;
   logic        reset;
   logic        issue_valid;
   logic [9:0]  issue_rs;
   logic [1:0]  issue_rs_used;
   logic [4:0]  issue_rd;
   logic        issue_wen;
   logic        issue_load;
   logic        flush;
   logic        stall;
   logic [3:0]  fwd_sel;
   logic [1:0]  stage_valid;
   logic        wb_wen;
   logic [4:0]  wb_rd;
`ifdef HAZARD_PERF_CNT_EN
   logic [31:0] perf_stall_cnt;
   logic [31:0] perf_flush_cnt;
`endif

   int checks = 0;
   int errors = 0;

   hazard_unit_param dut (
      .clk           (clk),
      .reset         (reset),
      .issue_valid   (issue_valid),
      .issue_rs      (issue_rs),
      .issue_rs_used (issue_rs_used),
      .issue_rd      (issue_rd),
      .issue_wen     (issue_wen),
      .issue_load    (issue_load),
      .flush         (flush),
      .stall         (stall),
      .fwd_sel       (fwd_sel),
      .stage_valid   (stage_valid),
      .wb_wen        (wb_wen),
      .wb_rd         (wb_rd)
`ifdef HAZARD_PERF_CNT_EN
      ,
      .perf_stall_cnt(perf_stall_cnt),
      .perf_flush_cnt(perf_flush_cnt)
`endif
   );

   always #5 clk = ~clk;

   typedef struct {
      logic       iv;
      logic [4:0] rs0, rs1;
      logic [1:0] used;
      logic [4:0] rd;
      logic       wen, load, fl;
      logic       e_stall;
      logic [1:0] e_sel0, e_sel1;
      logic [1:0] e_sv;
      logic       e_wbw;
      logic [4:0] e_wbrd;
   } vec_t;

   vec_t vecs[$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   task automatic add(input logic iv, input logic [4:0] rs0, input logic [4:0] rs1,
                      input logic [1:0] used, input logic [4:0] rd, input logic wen,
                      input logic load, input logic fl, input logic e_stall,
                      input logic [1:0] e_sel0, input logic [1:0] e_sel1,
                      input logic [1:0] e_sv, input logic e_wbw, input logic [4:0] e_wbrd);
      vec_t v;
      v.iv = iv; v.rs0 = rs0; v.rs1 = rs1; v.used = used; v.rd = rd; v.wen = wen;
      v.load = load; v.fl = fl; v.e_stall = e_stall; v.e_sel0 = e_sel0; v.e_sel1 = e_sel1;
      v.e_sv = e_sv; v.e_wbw = e_wbw; v.e_wbrd = e_wbrd;
      vecs.push_back(v);
   endtask

   task automatic drive(input logic iv, input logic [4:0] rs0, input logic [4:0] rs1,
                        input logic [1:0] used, input logic [4:0] rd, input logic wen,
                        input logic load, input logic fl);
      issue_valid   = iv;
      issue_rs      = {rs1, rs0};
      issue_rs_used = used;
      issue_rd      = rd;
      issue_wen     = wen;
      issue_load    = load;
      flush         = fl;
   endtask

   initial begin
      reset = 1'b1;
      drive(1'b0, 5'd0, 5'd0, 2'b00, 5'd0, 1'b0, 1'b0, 1'b0);
      repeat (2) @(negedge clk);
      #1;
      chk("reset_stall", {31'd0, stall}, 32'd0);
      chk("reset_fwd_sel", {28'd0, fwd_sel}, 32'd0);
      chk("reset_stage_valid", {30'd0, stage_valid}, 32'd0);
      chk("reset_wb", {26'd0, wb_wen, wb_rd}, 32'd0);
      reset = 1'b0;

      //   iv rs0 rs1 used rd wen load fl | stall sel0 sel1 sv wbw wbrd
      add(1, 1, 2, 2'b11, 5, 1, 0, 0,  0, 0, 0, 2'b00, 0, 0);   // add x5
      add(1, 5, 0, 2'b01, 10, 1, 0, 0, 0, 1, 0, 2'b01, 0, 0);   // use x5 from stage 1
      add(1, 5, 0, 2'b01, 0, 0, 0, 0,  0, 2, 0, 2'b11, 1, 5);   // use x5 from stage 2
      add(0, 0, 0, 2'b00, 0, 0, 0, 0,  0, 0, 0, 2'b11, 1, 10);
      add(1, 0, 0, 2'b00, 6, 1, 1, 0,  0, 0, 0, 2'b10, 0, 0);   // lw x6
      add(1, 3, 6, 2'b10, 8, 1, 0, 0,  1, 0, 1, 2'b01, 0, 0);   // load-use stall
      add(1, 3, 6, 2'b10, 8, 1, 0, 0,  0, 0, 2, 2'b10, 1, 6);   // retry, bubble in stage 1
      add(0, 0, 0, 2'b00, 0, 0, 0, 0,  0, 0, 0, 2'b01, 0, 8);
      add(1, 0, 0, 2'b00, 0, 1, 0, 0,  0, 0, 0, 2'b10, 1, 8);   // writer rd=x0
      add(1, 0, 7, 2'b11, 7, 1, 0, 0,  0, 0, 0, 2'b01, 0, 0);   // rs0=x0 never forwards
      add(1, 0, 7, 2'b01, 9, 1, 0, 0,  0, 0, 0, 2'b11, 0, 0);   // x7 unused; x0 writer no wb_wen
      add(1, 7, 0, 2'b00, 9, 1, 0, 0,  0, 0, 0, 2'b11, 1, 7);   // second x9 writer
      add(1, 9, 0, 2'b01, 0, 0, 0, 0,  0, 1, 0, 2'b11, 1, 9);   // youngest x9 wins
      add(0, 0, 0, 2'b00, 0, 0, 0, 0,  0, 0, 0, 2'b11, 1, 9);
      add(1, 0, 0, 2'b00, 4, 1, 1, 0,  0, 0, 0, 2'b10, 0, 0);   // lw x4
      add(1, 4, 0, 2'b01, 11, 1, 0, 1, 0, 1, 0, 2'b01, 0, 0);   // flush beats stall
      add(0, 0, 0, 2'b00, 0, 0, 0, 0,  0, 0, 0, 2'b10, 1, 4);
      add(0, 0, 0, 2'b00, 0, 0, 0, 0,  0, 0, 0, 2'b00, 0, 11);  // killed x11 never writes

      foreach (vecs[i]) begin
         @(negedge clk);
         drive(vecs[i].iv, vecs[i].rs0, vecs[i].rs1, vecs[i].used, vecs[i].rd,
               vecs[i].wen, vecs[i].load, vecs[i].fl);
         #1;
         chk($sformatf("v%0d_stall", i), {31'd0, stall}, {31'd0, vecs[i].e_stall});
         chk($sformatf("v%0d_fwd_sel", i), {28'd0, fwd_sel}, {28'd0, vecs[i].e_sel1, vecs[i].e_sel0});
         chk($sformatf("v%0d_stage_valid", i), {30'd0, stage_valid}, {30'd0, vecs[i].e_sv});
         chk($sformatf("v%0d_wb_wen", i), {31'd0, wb_wen}, {31'd0, vecs[i].e_wbw});
         chk($sformatf("v%0d_wb_rd", i), {27'd0, wb_rd}, {27'd0, vecs[i].e_wbrd});
      end
`ifdef HAZARD_PERF_CNT_EN
      chk("perf_stall_cnt", perf_stall_cnt, 32'd1);
      chk("perf_flush_cnt", perf_flush_cnt, 32'd1);
`endif

      // Async reset between edges while a load-use stall is live.
      @(negedge clk);
      drive(1'b1, 5'd0, 5'd0, 2'b00, 5'd3, 1'b1, 1'b0, 1'b0);   // add x3
      @(negedge clk);
      drive(1'b1, 5'd0, 5'd0, 2'b00, 5'd6, 1'b1, 1'b1, 1'b0);   // lw x6
      @(negedge clk);
      drive(1'b1, 5'd6, 5'd0, 2'b01, 5'd2, 1'b1, 1'b0, 1'b0);
      #1;
      chk("pre_reset_stall", {31'd0, stall}, 32'd1);
      chk("pre_reset_wb_wen", {31'd0, wb_wen}, 32'd1);
      chk("pre_reset_stage_valid", {30'd0, stage_valid}, 32'd3);
      #1;
      reset = 1'b1;
      #1;
      chk("async_reset_stall", {31'd0, stall}, 32'd0);
      chk("async_reset_fwd_sel", {28'd0, fwd_sel}, 32'd0);
      chk("async_reset_stage_valid", {30'd0, stage_valid}, 32'd0);
      chk("async_reset_wb_wen", {31'd0, wb_wen}, 32'd0);
`ifdef HAZARD_PERF_CNT_EN
      chk("async_reset_perf_stall", perf_stall_cnt, 32'd0);
      chk("async_reset_perf_flush", perf_flush_cnt, 32'd0);
`endif
      @(negedge clk);
      reset = 1'b0;
      drive(1'b0, 5'd0, 5'd0, 2'b00, 5'd0, 1'b0, 1'b0, 1'b0);
      @(negedge clk);
      #1;
      chk("post_reset_stage_valid", {30'd0, stage_valid}, 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/hazard_unit_param.md
Name: hazard_unit_param

Overview:
- Parametrised scoreboard that tracks in-flight register writers through a DEPTH-stage pipeline behind issue.
- Generates per-operand forwarding selects, load-use stall and branch/jump flush bubbles.
- Replaces the fixed 3-stage bypass/kill logic in the controller. The controller and datapath consume its selects; the pipeline registers remain in the datapath.

Parameters:
- DEPTH, 2, number of tracked stages after issue (1 = X, DEPTH = writeback stage); legal 2..6.
- NUM_SRC, 2, source operands per instruction; legal 1..3.
- REG_ADDR_W, 5, register index width.
- LOAD_READY_STAGE, 2, first stage whose load result is forwardable; legal 1..DEPTH.
- FLUSH_STAGE, 1, stage at which branches/jumps resolve; legal 1..DEPTH-1.
- Derived, not overridable: SEL_W = clog2(DEPTH+1).

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  reset; asynchronous, active-high
- issue_valid  in  1  instruction present at issue
- issue_rs  in  NUM_SRC*REG_ADDR_W  source indices, operand s at [s*REG_ADDR_W +: REG_ADDR_W]
- issue_rs_used  in  NUM_SRC  operand s actually read
- issue_rd  in  REG_ADDR_W  destination index
- issue_wen  in  1  instruction writes rd
- issue_load  in  1  instruction is a load
- flush  in  1  instruction at FLUSH_STAGE redirects the PC
- stall  out  1  hold PC and issue instruction this cycle
- fwd_sel  out  NUM_SRC*SEL_W  per operand: 0 = regfile, k = forward from stage k
- stage_valid  out  DEPTH  bit k-1 = stage k holds a live instruction
- wb_wen  out  1  regfile write enable of stage DEPTH (valid & wen & rd!=0)
- wb_rd  out  REG_ADDR_W  rd of stage DEPTH

Behaviour:
- State: entry[1..DEPTH], each holding {valid, wen, load, rd}. No other state except the optional counters.
- Reset (async): all entry fields 0. stall=0, fwd_sel=0, stage_valid=0, wb_wen=0, wb_rd=0. Reset asserted mid-operation clears everything immediately, with no clock edge required.
- Match(s,k): entry[k].valid & entry[k].wen & entry[k].rd==rs_s & rs_s!=0 & issue_rs_used[s] & issue_valid.
- fwd_sel[s] (combinational): smallest k with Match(s,k) (youngest writer wins); 0 if no match.
- Load-use: if that youngest match is a load with k < LOAD_READY_STAGE, then raw_stall=1 and fwd_sel[s] still reports k.
- stall = raw_stall & ~flush. Flush has priority over stall.
- Advance on each rising edge:
  - entry[k+1] <= entry[k] for k=1..DEPTH-1.
  - entry[1] <= {issue_valid & ~stall & ~flush, issue_wen, issue_load, issue_rd}.
- Flush:
  - On the edge where flush=1, entries moving into stages 2..FLUSH_STAGE get valid=0, and entry[1] gets valid=0.
  - The resolving instruction moves to FLUSH_STAGE+1 intact.
  - Older entries are unaffected.
- Stall inserts exactly one bubble per stalled cycle into stage 1. Stall drops automatically once the load reaches LOAD_READY_STAGE; with defaults that is 1 stall cycle.
- x0 (rd=0) never forwards, never stalls, and never asserts wb_wen.
- Latency: stall and fwd_sel are combinational from the issue inputs and entry state in the same cycle. stage_valid, wb_wen and wb_rd are register outputs.

Optional Feature:
- Macro HAZARD_PERF_CNT_EN.
- Defined: adds outputs perf_stall_cnt [31:0] and perf_flush_cnt [31:0].
  - perf_stall_cnt increments each cycle stall=1; perf_flush_cnt increments each cycle flush=1.
  - Both saturate at 32'hFFFFFFFF and clear on reset.
- Undefined: ports and counters are absent; all other behaviour is identical.

Test Plan:
- Back-to-back ALU dependency (defaults): issue add x5 (wen=1), next cycle issue rs0=x5 -> fwd_sel[0]=1, stall=0. Same operand one cycle later -> fwd_sel[0]=2.
- Load-use: issue lw x6 (load=1), then rs1=x6 -> stall=1 for exactly 1 cycle, stage_valid=2'b10 on the following cycle, then fwd_sel[1]=2, stall=0.
- x0 and unused operand: writer rd=0 then rs0=0, plus a writer x7 with issue_rs_used[1]=0 and rs1=x7 -> fwd_sel=0, stall=0, wb_wen=0 when the rd=0 writer is at stage DEPTH.
- Youngest-wins: writers x9 at stage 2 and stage 1, issue rs0=x9 -> fwd_sel[0]=1.
- Flush vs stall: load at stage 1 and dependent instruction at issue, flush=1 in the same cycle -> stall=0; stage 1 is invalid after the edge, and the killed instruction never produces wb_wen.
- Async reset mid-stall: assert reset between edges while stall=1 -> stall, fwd_sel, stage_valid and wb_wen read 0 immediately; with HAZARD_PERF_CNT_EN, both counters read 0.
